p5_exec_sequencer: RTL and testbench
====================================

// Module: p5_exec_sequencer
// PURPOSE
//  Execute-stage sequencer for the Simple RISC Machine datapath; it drives and consumes the 8x16 register file.
//  On a start command it reads Rn and Rm from the register file over successive cycles, then shifts Rm and applies the ALU op.
//  It writes the result back to Rd and updates the Z/N/V status flags.
//  The block sits between the instruction controller and the register file, and owns the A, B and C pipeline registers.
// PARAMETERS
//  DW  16  datapath width (the register-file word width)
//  AW  3   register index width (8 registers)
// PORTS
//  clk       in   1    rising-edge clock (same clock as the register file)
//  reset_n   in   1    asynchronous, active-low reset
//  start     in   1    command strobe; sampled only in IDLE
//  aluop     in   2    00 ADD, 01 SUB, 10 AND, 11 MVN (~B')
//  shift     in   2    B shifter: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (MSB replicated)
//  rn        in   AW   A operand register
//  rm        in   AW   B operand register
//  rd        in   AW   destination register
//  asel      in   1    1: A forced to 0 (MOV/MVN form); the READ_A cycle is skipped
//  nowb      in   1    1: compare form; flags are updated, no writeback
//  readnum   out  AW   register-file read index
//  rf_data   in   DW   register-file read data (combinational from readnum)
//  writenum  out  AW   register-file write index
//  write     out  1    register-file write enable
//  wb_data   out  DW   register-file write data (= C register)
//  busy      out  1    high in every state except IDLE
//  done      out  1    single-cycle pulse in the WB state
//  status    out  3    {V,N,Z}, registered
// BEHAVIOUR
//  - Reset: state=IDLE; A, B, C, status, and the captured command = 0. Outputs: write=0, done=0, busy=0, readnum=0, writenum=0.
//  - Reset is asynchronous and takes effect mid-operation. A command in flight is dropped and no write is issued.
//  - Command capture: start high in IDLE latches aluop/shift/rn/rm/rd/asel/nowb. Later input changes are ignored until the next IDLE.
//  - start while busy is ignored; it is not queued.
//  - FSM (Moore), one state per cycle:
//      IDLE  : if start, go to READ_A (asel=0) or READ_B (asel=1)
//      READ_A: readnum=rn; A<=rf_data at the clock edge; go to READ_B
//      READ_B: readnum=rm; B<=rf_data; if asel, A<=0; go to EXEC
//      EXEC  : C<=ALU(A, shift(B)); status<=flags; go to WB
//      WB    : done=1; write=~nowb; writenum=rd; wb_data=C; go to IDLE
//  - Outside READ_A and READ_B, readnum holds rm. writenum=rd in all non-IDLE states. write is high only in WB.
//  - Latency from the start edge: asel=0 -> WB at cycle 4; asel=1 -> WB at cycle 3. The register-file write lands at the end of WB.
//  - Next-command timing: start may be reasserted in the cycle after WB (IDLE). Back-to-back throughput is 1 command per 5 (or 4) cycles.
//  - Read-after-write: a new command reads registers after the previous WB edge, so it sees the updated value without bypass.
//  - Arithmetic: all operations are modulo 2^DW.
//      SUB = A + ~B' + 1.
//      Z = (result==0).
//      N = result[DW-1].
//      V = signed overflow for ADD/SUB, 0 for AND/MVN.
//  - Flags update in every EXEC, including compare commands. C also updates when nowb=1 but is not written back.
//  - rd may equal rn or rm; the operands were already captured, so the result is well defined.
// STRUCTURE
//  - Shared package p5_defs: DW/AW constants, ALU op codes, shift codes, FSM state encodings (3-bit).
//  - One sub-module: p5_shift_alu (combinational shifter + ALU + flag generation). The FSM and A/B/C/status registers stay in this module.
// TESTING
//  1. R1=0x0005, R2=0x0003. ADD rn=1 rm=2 rd=3 shift=LSL1 -> WB at cycle 4, R3=0x000B, status=000.
//  2. R4=0x8000, R5=0x0001. SUB rn=4 rm=5 rd=6 -> R6=0x7FFF, V=1 N=0 Z=0.
//  3. R1=R2=0x1234. SUB with nowb=1 -> Z=1; write never asserted; done pulses once; R-file unchanged.
//  4. R7=0x8004. asel=1 ADD rm=7 shift=ASR1 rd=0 -> WB at cycle 3, R0=0xC002, N=1. Second case with MVN, rm=7, shift=none -> 0x7FFB.
//  5. Reset: drop reset_n in EXEC -> state=IDLE immediately, write=0, status=000, and no write occurs. Also pulse start during READ_B -> ignored; exactly one done.
//  6. Back-to-back: R1=1. ADD R1=R1+R1 issued twice, start in each IDLE -> R1=2, then R1=4 (read-after-write correct).

Source files
------------

// File: rtl/p5_exec_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: widths, ALU/shift codes,
// FSM encodings and the captured-command record.
package p5_defs;
  localparam int DW = 16;
  localparam int AW = 3;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_MVN = 2'b11} aluop_e;
  typedef enum logic [1:0] {SH_NONE = 2'b00, SH_LSL1 = 2'b01, SH_LSR1 = 2'b10, SH_ASR1 = 2'b11} shift_e;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0]    aluop;
    logic [1:0]    shift;
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    logic [AW-1:0] rd;
    logic          asel;
    logic          nowb;
  } cmd_t;
endpackage

// File: rtl/p5_exec_sequencer_if.sv
// Controller/register-file facing signals of the execute sequencer.
interface p5_exec_sequencer_if import p5_defs::*; ();
  logic          start;
  logic [1:0]    aluop;
  logic [1:0]    shift;
  logic [AW-1:0] rn, rm, rd;
  logic          asel, nowb;
  logic [AW-1:0] readnum, writenum;
  logic [DW-1:0] rf_data, wb_data;
  logic          write, busy, done;
  logic [2:0]    status;

  modport master (output start, aluop, shift, rn, rm, rd, asel, nowb, rf_data,
                  input  readnum, writenum, write, wb_data, busy, done, status);
  modport slave  (input  start, aluop, shift, rn, rm, rd, asel, nowb, rf_data,
                  output readnum, writenum, write, wb_data, busy, done, status);
endinterface

// File: rtl/p5_exec_sequencer_shift_alu.sv
// Combinational B shifter, ALU and {V,N,Z} flag generation.
module p5_shift_alu import p5_defs::*; (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    aluop,
  input  logic [1:0]    shift,
  output logic [DW-1:0] result,
  output logic [2:0]    flags
);
  logic [DW-1:0] bs;
  logic          v;

  always_comb begin
    bs = b;
    case (shift_e'(shift))
      SH_LSL1: bs = {b[DW-2:0], 1'b0};
      SH_LSR1: bs = {1'b0, b[DW-1:1]};
      SH_ASR1: bs = {b[DW-1], b[DW-1:1]};
      default: bs = b;
    endcase

    result = '0;
    v      = 1'b0;
    // Overflow: operands agree in sign (after B inversion for SUB) but the result does not.
    case (aluop_e'(aluop))
      OP_ADD: begin
        result = a + bs;
        v      = (a[DW-1] == bs[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        result = a + ~bs + DW'(1);
        v      = (a[DW-1] != bs[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_AND:  result = a & bs;
      default: result = ~bs;
    endcase

    flags = {v, result[DW-1], result == '0};
  end
endmodule

// File: rtl/p5_exec_sequencer.sv
// Execute-stage sequencer: reads Rn/Rm, runs shift+ALU, writes back Rd and
// updates {V,N,Z}. Owns the A, B, C and status registers.
module p5_exec_sequencer import p5_defs::*; (
  input logic               clk,
  input logic               reset_n,
  p5_exec_sequencer_if.slave bus
);
  state_e        state, state_nx;
  cmd_t          cmd;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [2:0]    status_q;
  logic [DW-1:0] alu_res;
  logic [2:0]    alu_flags;

  p5_shift_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .aluop  (cmd.aluop),
    .shift  (cmd.shift),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.write    = 1'b0;
    bus.readnum  = cmd.rm;
    bus.writenum = cmd.rd;
    case (state)
      S_IDLE: begin
        bus.busy     = 1'b0;
        bus.writenum = '0;
        if (bus.start) state_nx = bus.asel ? S_READ_B : S_READ_A;
      end
      S_READ_A: begin
        bus.readnum = cmd.rn;
        state_nx    = S_READ_B;
      end
      S_READ_B: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB;
      S_WB: begin
        bus.done  = 1'b1;
        bus.write = ~cmd.nowb;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start)
          cmd <= '{aluop: bus.aluop, shift: bus.shift, rn: bus.rn, rm: bus.rm,
                   rd: bus.rd, asel: bus.asel, nowb: bus.nowb};
        S_READ_A: a_q <= bus.rf_data;
        S_READ_B: begin
          b_q <= bus.rf_data;
          if (cmd.asel) a_q <= '0;
        end
        // Compare commands still refresh C and flags; only the writeback is suppressed.
        S_EXEC: begin
          c_q      <= alu_res;
          status_q <= alu_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.wb_data = c_q;
  assign bus.status  = status_q;
endmodule

// File: tb/tb_p5_exec_sequencer.sv
// Directed bench: behavioural 8x16 register file, scoreboard of expected
// writebacks, checks on every done pulse plus end-of-test register contents.
module tb_p5_exec_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  p5_exec_sequencer_if bus();
  p5_exec_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic [2:0]  st;
    logic        wr;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] rf [8];
  logic [15:0] snap [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [15:0] pre_val = 16'h0;
  int          cyc = 0;
  int          nvec = 0;
  int          nfail = 0;
  int          ndone = 0;

  initial for (int i = 0; i < 8; i++) rf[i] = 16'h0;

  assign bus.rf_data = rf[bus.readnum];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we)         rf[pre_idx] <= pre_val;
    else if (bus.write) rf[bus.writenum] <= bus.wb_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model works on signed integers rather than bit tricks.
  function automatic void model(input logic [1:0] op, input logic [1:0] sh,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [2:0] st);
    int ai, bi, sa, sb, s;
    logic v;
    ai = int'(a);
    bi = int'(b);
    case (sh)
      2'd1: bi = (bi * 2) % 65536;
      2'd2: bi = bi / 2;
      2'd3: bi = bi / 2 + ((bi >= 32768) ? 32768 : 0);
      default: ;
    endcase
    sa = (ai >= 32768) ? ai - 65536 : ai;
    sb = (bi >= 32768) ? bi - 65536 : bi;
    v  = 1'b0;
    case (op)
      2'd0: begin s = sa + sb; v = (s > 32767) || (s < -32768); end
      2'd1: begin s = sa - sb; v = (s > 32767) || (s < -32768); end
      2'd2: s = ai & bi;
      default: s = 65535 - bi;
    endcase
    r  = s[15:0];
    st = {v, r[15], r == 16'h0};
  endfunction

  task automatic set_reg(input int idx, input logic [15:0] val);
    pre_we  = 1'b1;
    pre_idx = idx[2:0];
    pre_val = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sh, input int rn_i,
                       input int rm_i, input int rd_i, input logic asel_i, input logic nowb_i);
    exp_t e;
    logic [15:0] av;
    av = asel_i ? 16'h0 : rf[rn_i];
    model(op, sh, av, rf[rm_i], e.val, e.st);
    e.rd  = rd_i[2:0];
    e.wr  = ~nowb_i;
    e.lat = asel_i ? 3 : 4;
    bus.start = 1'b1;
    bus.aluop = op;  bus.shift = sh;
    bus.rn = rn_i[2:0]; bus.rm = rm_i[2:0]; bus.rd = rd_i[2:0];
    bus.asel = asel_i; bus.nowb = nowb_i;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Scramble the command inputs; the captured copy must be used.
    bus.aluop = ~op; bus.shift = ~sh;
    bus.rn = ~bus.rn; bus.rm = ~bus.rm; bus.rd = ~bus.rd;
    bus.asel = ~asel_i; bus.nowb = ~nowb_i;
    e.t0 = cyc;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
    end
    check({tag, "_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      ndone++;
      if (q.size() == 0) check("unexpected_done", q.size(), 1);
      else begin
        mon_e = q.pop_front();
        check("writenum", bus.writenum, mon_e.rd);
        check("wb_data",  bus.wb_data,  mon_e.val);
        check("write",    bus.write,    mon_e.wr);
        check("status",   bus.status,   mon_e.st);
        check("latency",  cyc - mon_e.t0 + 1, mon_e.lat);
      end
    end
    if (reset_n && bus.write) check("write_only_wb", bus.done, 1);
  end

  initial begin
    int nd0, ta, tb;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.aluop = 2'd0; bus.shift = 2'd0;
    bus.rn = 3'd0; bus.rm = 3'd0; bus.rd = 3'd0; bus.asel = 1'b0; bus.nowb = 1'b0;
    #1;
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    check("rst_write",    bus.write,    0);
    check("rst_readnum",  bus.readnum,  0);
    check("rst_writenum", bus.writenum, 0);
    check("rst_status",   bus.status,   0);
    check("rst_wb_data",  bus.wb_data,  0);
    @(negedge clk) reset_n = 1'b1;

    // ADD with LSL1
    set_reg(1, 16'h0005); set_reg(2, 16'h0003);
    issue(2'b00, 2'b01, 1, 2, 3, 1'b0, 1'b0);
    wait_idle("t1");
    check("t1_r3", rf[3], 16'h000B);
    check("t1_status", bus.status, 3'b000);

    // SUB overflow
    set_reg(4, 16'h8000); set_reg(5, 16'h0001);
    issue(2'b01, 2'b00, 4, 5, 6, 1'b0, 1'b0);
    wait_idle("t2");
    check("t2_r6", rf[6], 16'h7FFF);
    check("t2_status", bus.status, 3'b100);

    // Compare form: flags only
    set_reg(1, 16'h1234); set_reg(2, 16'h1234);
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
    nd0 = ndone;
    issue(2'b01, 2'b00, 1, 2, 3, 1'b0, 1'b1);
    wait_idle("t3");
    check("t3_status", bus.status, 3'b001);
    check("t3_dones", ndone - nd0, 1);
    for (int i = 0; i < 8; i++) check("t3_rf_unchanged", rf[i], snap[i]);

    // asel forms: MVN then ADD with ASR1
    set_reg(7, 16'h8004);
    issue(2'b11, 2'b00, 2, 7, 0, 1'b1, 1'b0);
    wait_idle("t4a");
    check("t4_mvn_r0", rf[0], 16'h7FFB);
    check("t4_mvn_status", bus.status, 3'b000);
    issue(2'b00, 2'b11, 2, 7, 0, 1'b1, 1'b0);
    wait_idle("t4b");
    check("t4_asr_r0", rf[0], 16'hC002);
    check("t4_asr_status", bus.status, 3'b010);

    // Reset in EXEC drops the command
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
    issue(2'b00, 2'b00, 1, 2, 5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_busy_exec", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_busy",     bus.busy,     0);
    check("t5_write",    bus.write,    0);
    check("t5_done",     bus.done,     0);
    check("t5_status",   bus.status,   0);
    check("t5_readnum",  bus.readnum,  0);
    check("t5_writenum", bus.writenum, 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) check("t5_rf_unchanged", rf[i], snap[i]);

    // start during READ_B is ignored
    nd0 = ndone;
    issue(2'b10, 2'b00, 1, 2, 4, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.rd = 3'd5; bus.asel = 1'b1; bus.aluop = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("t5b");
    repeat (6) @(negedge clk);
    check("t5b_dones", ndone - nd0, 1);
    check("t5b_r4", rf[4], 16'h1234);
    check("t5b_r5", rf[5], snap[5]);

    // Back-to-back read-after-write
    set_reg(1, 16'h0001);
    issue(2'b00, 2'b00, 1, 1, 1, 1'b0, 1'b0);
    ta = cyc;
    wait_idle("t6a");
    check("t6_r1_first", rf[1], 16'h0002);
    issue(2'b00, 2'b00, 1, 1, 1, 1'b0, 1'b0);
    tb = cyc;
    wait_idle("t6b");
    check("t6_r1_second", rf[1], 16'h0004);
    check("t6_spacing", tb - ta, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
